aib_adapt_fifo_ctrl: RTL

AIB_ADAPT_FIFO_CTRL -- requirements
Module: aib_adapt_fifo_ctrl

---
 rtl/aib_adapt_fifo_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/aib_adapt_fifo_ctrl.sv
// rtl/aib_adapt_fifo_ctrl.sv - AIB adapter FIFO pointer/count control with phase-comp auto read
module aib_adapt_fifo_ctrl #(
  parameter int AWIDTH = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_mode,
  input  logic [AWIDTH:0]   cfg_start_lvl,
  input  logic [AWIDTH:0]   cfg_af_lvl,
  input  logic [AWIDTH:0]   cfg_ae_lvl,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              clr_sticky,
  output logic [DEPTH-1:0]  wr_ptr_one_hot,
  output logic [DEPTH-1:0]  rd_ptr_one_hot,
  output logic [AWIDTH-1:0] wr_ptr_bin,
  output logic [AWIDTH-1:0] rd_ptr_bin,
  output logic [AWIDTH:0]   numdata,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              rd_fire,
  output logic              ovf_sticky,
  output logic              udf_sticky
);

  localparam logic [AWIDTH:0]   DEPTH_C  = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST_PTR = AWIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t            state;
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH:0]   count;
  logic [AWIDTH:0]   start_eff;
  logic              wa;
  logic              udf_cond;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= cfg_af_lvl);
  assign almost_empty = (count <= cfg_ae_lvl);
  assign numdata      = count;
  assign wr_ptr_bin   = wr_ptr;
  assign rd_ptr_bin   = rd_ptr;

  assign wa       = wr_en & ~full;
  assign rd_fire  = cfg_mode ? ((state == RUN) & ~empty) : (rd_en & ~empty);
  assign udf_cond = cfg_mode ? ((state == RUN) & empty) : (rd_en & empty);

  // Out-of-range start levels are clamped so the FSM can always leave FILL.
  always_comb begin
    start_eff = cfg_start_lvl;
    if (cfg_start_lvl == '0)
      start_eff = (AWIDTH + 1)'(1);
    else if (cfg_start_lvl > DEPTH_C)
      start_eff = DEPTH_C;
  end

  always_comb begin
    wr_ptr_one_hot = '0;
    rd_ptr_one_hot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_ptr_one_hot[i] = (wr_ptr == AWIDTH'(i));
      rd_ptr_one_hot[i] = (rd_ptr == AWIDTH'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wa)
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (rd_fire)
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (wa && !rd_fire)
        count <= count + 1'b1;
      else if (!wa && rd_fire)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (!cfg_mode) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= FILL;
        FILL:    if (count >= start_eff) state <= RUN;
        RUN:     if (count == '0) state <= FILL;
        default: state <= IDLE;
      endcase
    end
  end

  // A new error in the same cycle as clr_sticky keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      ovf_sticky <= (wr_en & full) | (ovf_sticky & ~clr_sticky);
      udf_sticky <= udf_cond | (udf_sticky & ~clr_sticky);
    end
  end

endmodule
